// File: rtl/complex_div_seq_if.sv
// Handshake bundle for complex_div_seq: operand channel in, quotient channel out.
interface complex_div_seq_if #(
  parameter int WORD_SZ = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WORD_SZ-1:0] cpx_A;
  logic [WORD_SZ-1:0] cpx_B;
  logic               out_valid;
  logic               out_ready;
  logic [WORD_SZ-1:0] cpx_C;
  logic               div_zero;
  logic               sat;

  modport master (
    output in_valid, cpx_A, cpx_B, out_ready,
    input  in_ready, out_valid, cpx_C, div_zero, sat
  );

  modport slave (
    input  in_valid, cpx_A, cpx_B, out_ready,
    output in_ready, out_valid, cpx_C, div_zero, sat
  );
endinterface

// File: rtl/complex_div_seq.sv
// Sequential fixed-point complex divider C = A*conj(B)/|B|^2 using one multiply
// cycle and two parallel restoring dividers; truncates toward zero and saturates.
module complex_div_seq #(
  parameter int WORD_MID  = 16,
  parameter int WORD_SZ   = 32,
  parameter int FRAC_BITS = 6,
  parameter int DIV_ITERS = 38
) (
  input logic               clk,
  input logic               rst,
  complex_div_seq_if.slave  bus
);
  localparam int PW = 2 * WORD_MID;
  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0]        LAST_ITER = CW'(DIV_ITERS - 1);
  localparam logic [DIV_ITERS-1:0] POS_LIM   = DIV_ITERS'(2 ** (WORD_MID - 1) - 1);
  localparam logic [DIV_ITERS-1:0] NEG_LIM   = DIV_ITERS'(2 ** (WORD_MID - 1));
  localparam logic [WORD_MID-1:0]  POS_MAX   = {1'b0, {(WORD_MID - 1){1'b1}}};
  localparam logic [WORD_MID-1:0]  NEG_MAX   = {1'b1, {(WORD_MID - 1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MULT, DIV, SAT, DONE} state_t;

  // One restoring step: returns {quotient bit, new remainder}. Remainder stays below den.
  function automatic logic [PW:0] div_step(input logic [PW-1:0] rem,
                                           input logic [PW-1:0] den,
                                           input logic          bit_in);
    logic [PW:0] trial;
    trial = {rem, bit_in};
    if (trial >= {1'b0, den}) begin
      div_step = {1'b1, trial[PW-1:0] - den};
    end else begin
      div_step = {1'b0, trial[PW-1:0]};
    end
  endfunction

  // Apply sign to a magnitude quotient and clamp; returns {clamped, value}.
  function automatic logic [WORD_MID:0] clamp_comp(input logic                 neg,
                                                   input logic [DIV_ITERS-1:0] q);
    logic [WORD_MID-1:0] neg_v;
    neg_v = ~q[WORD_MID-1:0] + {{(WORD_MID - 1){1'b0}}, 1'b1};
    if (!neg) begin
      clamp_comp = (q > POS_LIM) ? {1'b1, POS_MAX} : {1'b0, q[WORD_MID-1:0]};
    end else begin
      clamp_comp = (q > NEG_LIM) ? {1'b1, NEG_MAX} : {1'b0, neg_v};
    end
  endfunction

  state_t state, state_next;

  logic [WORD_SZ-1:0]   a_r, b_r;
  logic                 neg_re_r, neg_im_r;
  logic [PW-1:0]        den_r;
  logic [DIV_ITERS-1:0] dvd_re_r, dvd_im_r;
  logic [PW-1:0]        rem_re_r, rem_im_r;
  logic [DIV_ITERS-1:0] q_re_r, q_im_r;
  logic [CW-1:0]        iter_r;
  logic                 in_ready_r, out_valid_r, div_zero_r, sat_r;
  logic [WORD_SZ-1:0]   cpx_c_r;

  logic signed [WORD_MID-1:0] ar_s, ai_s, br_s, bi_s;
  logic signed [PW-1:0]       p_rr_s, p_ii_s, p_ir_s, p_ri_s, p_bbr_s, p_bbi_s;
  logic [PW:0]                num_re_s, num_im_s, step_re_s, step_im_s;
  logic [PW-1:0]              mag_re_s, mag_im_s, den_s;
  logic [WORD_MID:0]          clamp_re_s, clamp_im_s;
  logic                       accept_s;

  assign accept_s = bus.in_valid && (state == IDLE);

  assign ar_s = a_r[WORD_SZ-1:WORD_MID];
  assign ai_s = a_r[WORD_MID-1:0];
  assign br_s = b_r[WORD_SZ-1:WORD_MID];
  assign bi_s = b_r[WORD_MID-1:0];

  assign p_rr_s  = ar_s * br_s;
  assign p_ii_s  = ai_s * bi_s;
  assign p_ir_s  = ai_s * br_s;
  assign p_ri_s  = ar_s * bi_s;
  assign p_bbr_s = br_s * br_s;
  assign p_bbi_s = bi_s * bi_s;

  assign num_re_s = {p_rr_s[PW-1], p_rr_s} + {p_ii_s[PW-1], p_ii_s};
  assign num_im_s = {p_ir_s[PW-1], p_ir_s} - {p_ri_s[PW-1], p_ri_s};
  assign den_s    = p_bbr_s + p_bbi_s;
  // |num| never exceeds 2^(PW-1), so it fits in PW bits unsigned.
  assign mag_re_s = (num_re_s[PW-1:0] ^ {PW{num_re_s[PW]}}) + {{(PW - 1){1'b0}}, num_re_s[PW]};
  assign mag_im_s = (num_im_s[PW-1:0] ^ {PW{num_im_s[PW]}}) + {{(PW - 1){1'b0}}, num_im_s[PW]};

  assign step_re_s  = div_step(rem_re_r, den_r, dvd_re_r[DIV_ITERS-1]);
  assign step_im_s  = div_step(rem_im_r, den_r, dvd_im_r[DIV_ITERS-1]);
  assign clamp_re_s = clamp_comp(neg_re_r, q_re_r);
  assign clamp_im_s = clamp_comp(neg_im_r, q_im_r);

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.cpx_C     = cpx_c_r;
  assign bus.div_zero  = div_zero_r;
  assign bus.sat       = sat_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept_s ? MULT : IDLE;
      MULT:    state_next = DIV;
      DIV:     state_next = (iter_r == LAST_ITER) ? SAT : DIV;
      SAT:     state_next = DONE;
      DONE:    state_next = bus.out_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, multiply, iterative divide and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {WORD_SZ{1'b0}};
      b_r         <= {WORD_SZ{1'b0}};
      neg_re_r    <= 1'b0;
      neg_im_r    <= 1'b0;
      den_r       <= {PW{1'b0}};
      dvd_re_r    <= {DIV_ITERS{1'b0}};
      dvd_im_r    <= {DIV_ITERS{1'b0}};
      rem_re_r    <= {PW{1'b0}};
      rem_im_r    <= {PW{1'b0}};
      q_re_r      <= {DIV_ITERS{1'b0}};
      q_im_r      <= {DIV_ITERS{1'b0}};
      iter_r      <= {CW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      cpx_c_r     <= {WORD_SZ{1'b0}};
      div_zero_r  <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      in_ready_r <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept_s) begin
            a_r <= bus.cpx_A;
            b_r <= bus.cpx_B;
          end
        end
        MULT: begin
          neg_re_r <= num_re_s[PW];
          neg_im_r <= num_im_s[PW];
          den_r    <= den_s;
          dvd_re_r <= {mag_re_s, {FRAC_BITS{1'b0}}};
          dvd_im_r <= {mag_im_s, {FRAC_BITS{1'b0}}};
          rem_re_r <= {PW{1'b0}};
          rem_im_r <= {PW{1'b0}};
          q_re_r   <= {DIV_ITERS{1'b0}};
          q_im_r   <= {DIV_ITERS{1'b0}};
          iter_r   <= {CW{1'b0}};
        end
        DIV: begin
          rem_re_r <= step_re_s[PW-1:0];
          rem_im_r <= step_im_s[PW-1:0];
          q_re_r   <= {q_re_r[DIV_ITERS-2:0], step_re_s[PW]};
          q_im_r   <= {q_im_r[DIV_ITERS-2:0], step_im_s[PW]};
          dvd_re_r <= {dvd_re_r[DIV_ITERS-2:0], 1'b0};
          dvd_im_r <= {dvd_im_r[DIV_ITERS-2:0], 1'b0};
          iter_r   <= iter_r + CW'(1);
        end
        SAT: begin
          out_valid_r <= 1'b1;
          if (den_r == {PW{1'b0}}) begin
            cpx_c_r    <= {WORD_SZ{1'b0}};
            div_zero_r <= 1'b1;
            sat_r      <= 1'b0;
          end else begin
            cpx_c_r    <= {clamp_re_s[WORD_MID-1:0], clamp_im_s[WORD_MID-1:0]};
            div_zero_r <= 1'b0;
            sat_r      <= clamp_re_s[WORD_MID] | clamp_im_s[WORD_MID];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_complex_div_seq.sv
// Self-checking bench for complex_div_seq: directed cases, random operands
// against an integer reference model, back-pressure and reset behaviour.
module tb_complex_div_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  complex_div_seq_if #(.WORD_SZ(32)) bus ();

  complex_div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: one component of (A*conj(B))/|B|^2 in Q.6, truncated toward zero, clamped.
  function automatic logic [16:0] ref_comp(input longint n, input longint den);
    longint mag;
    longint v;
    mag = ((n < 0) ? -n : n) * 64 / den;
    v   = (n < 0) ? -mag : mag;
    if (v > 32767) return {1'b1, 16'h7FFF};
    else if (v < -32768) return {1'b1, 16'h8000};
    else return {1'b0, v[15:0]};
  endfunction

  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] c, output logic dz, output logic s);
    longint ar, ai, br, bi, nr, ni, den;
    logic [16:0] rr, ri;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    nr  = ar * br + ai * bi;
    ni  = ai * br - ar * bi;
    den = br * br + bi * bi;
    if (den == 0) begin
      c = 32'h0; dz = 1'b1; s = 1'b0;
    end else begin
      rr = ref_comp(nr, den);
      ri = ref_comp(ni, den);
      c  = {rr[15:0], ri[15:0]};
      dz = 1'b0;
      s  = rr[16] | ri[16];
    end
  endfunction

  // Issue one operation (called at a negedge) and wait for out_valid; lat counts edges after accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] c, output logic dz, output logic s, output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 200) begin
      @(posedge clk); @(negedge clk); w++;
    end
    bus.cpx_A = a; bus.cpx_B = b; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cpx_A = $urandom; bus.cpx_B = $urandom;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    c = bus.cpx_C; dz = bus.div_zero; s = bus.sat;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if ({bus.cpx_C, bus.div_zero, bus.sat} !== 34'h0) begin n_bad++;
      $display("FAIL reset_outputs: got C=%h dz=%b sat=%b want 0", bus.cpx_C, bus.div_zero, bus.sat); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [8] = '{32'h0040_0080, 32'hFE70_00A0, 32'h0050_00A0, 32'h7FFF_0000,
                            32'h8000_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000};
    logic [31:0] tb [8] = '{32'h00C0_0100, 32'hFE70_00A0, 32'h0000_0000, 32'h0001_0000,
                            32'h0001_0000, 32'h0080_0000, 32'h1234_5678, 32'h0040_0000};
    logic [31:0] tc [8] = '{32'h001C_0005, 32'h0040_0000, 32'h0000_0000, 32'h7FFF_0000,
                            32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
    logic [1:0]  tf [8] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [31:0] c;
    logic dz, s;
    int lat;
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tb[i], c, dz, s, lat);
      n_cmp++; if (lat !== 40) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want 40", i, lat); end
      n_cmp++; if (c !== tc[i]) begin n_bad++; $display("FAIL dir%0d_cpx_C: got %h want %h", i, c, tc[i]); end
      n_cmp++; if ({dz, s} !== tf[i]) begin n_bad++; $display("FAIL dir%0d_flags: got dz,sat=%b%b want %b", i, dz, s, tf[i]); end
      consume();
      n_cmp++; if (bus.cpx_C !== tc[i] || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++;
        $display("FAIL dir%0d_idle_hold: got C=%h rdy=%b vld=%b want C=%h rdy=1 vld=0",
                 i, bus.cpx_C, bus.in_ready, bus.out_valid, tc[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, c, ec;
    logic [15:0] t0, t1;
    logic dz, s, edz, es;
    int lat;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      t0 = 16'($urandom_range(0, 128)) - 16'd64;
      t1 = 16'($urandom_range(0, 128)) - 16'd64;
      case ($urandom_range(0, 3))
        1: b = {t0, t1};
        2: b = 32'h0;
        3: a = {t0, t1};
        default: ;
      endcase
      ref_model(a, b, ec, edz, es);
      do_op(a, b, c, dz, s, lat);
      n_cmp++; if ({c, dz, s, lat} !== {ec, edz, es, 32'd40}) begin n_bad++;
        $display("FAIL rand%0d: A=%h B=%h got C=%h dz=%b sat=%b lat=%0d want C=%h dz=%b sat=%b lat=40",
                 i, a, b, c, dz, s, lat, ec, edz, es); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c, ec;
    logic dz, s, edz, es;
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = {16'($urandom_range(1, 300)), 16'($urandom_range(0, 300))};
      ref_model(a, b, ec, edz, es);
      do_op(a, b, c, dz, s, lat);
      n_cmp++; if ({c, dz, s, lat} !== {ec, edz, es, 32'd40}) begin n_bad++;
        $display("FAIL b2b%0d: got C=%h dz=%b sat=%b lat=%0d want C=%h dz=%b sat=%b lat=40",
                 i, c, dz, s, lat, ec, edz, es); end
    end
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] c;
    logic dz, s;
    int lat;
    do_op(32'h0040_0080, 32'h00C0_0100, c, dz, s, lat);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0]; bus.cpx_A = $urandom; bus.cpx_B = $urandom;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.cpx_C !== 32'h001C_0005 ||
                   bus.div_zero !== 1'b0 || bus.sat !== 1'b0) begin n_bad++;
        $display("FAIL hold%0d: got vld=%b rdy=%b C=%h dz=%b sat=%b want 1 0 001c0005 0 0",
                 k, bus.out_valid, bus.in_ready, bus.cpx_C, bus.div_zero, bus.sat); end
    end
    bus.in_valid = 1'b0;
    consume();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL release: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] c;
    logic dz, s;
    int lat;
    int seen;
    bus.cpx_A = 32'h0040_0080; bus.cpx_B = 32'h00C0_0100; bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.cpx_C !== 32'h0) begin n_bad++;
      $display("FAIL rst_mid_div: got rdy=%b vld=%b C=%h want 1 0 0", bus.in_ready, bus.out_valid, bus.cpx_C); end
    // Reset and in_valid together: nothing may be accepted.
    rst = 1'b1; bus.in_valid = 1'b1; bus.cpx_A = 32'h0040_0080; bus.cpx_B = 32'h00C0_0100;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 45; k++) begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_vs_in_valid: got %0d busy cycles want 0", seen); end
    // Reset and out_ready together in DONE.
    do_op(32'hFE70_00A0, 32'hFE70_00A0, c, dz, s, lat);
    n_cmp++; if (c !== 32'h0040_0000) begin n_bad++; $display("FAIL pre_rst_done: got %h want 00400000", c); end
    rst = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.cpx_C !== 32'h0) begin n_bad++;
      $display("FAIL rst_in_done: got rdy=%b vld=%b C=%h want 1 0 0", bus.in_ready, bus.out_valid, bus.cpx_C); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.cpx_A = 32'h0; bus.cpx_B = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/complex_div_seq.md
Name: complex_div_seq

Overview:
- Sequential fixed-point complex divider for the butterfly/FFT datapath: cpx_C = cpx_A / cpx_B.
- Computes A·conj(B) / |B|², using one shared multiply stage and two parallel restoring dividers (real and imaginary).
- Complex words are packed {real[31:16], imag[15:0]}, each half signed two's complement with FRAC_BITS fractional bits.
- Valid/ready on both sides; one operation in flight; fixed latency.

Parameters:
- WORD_MID, 16, width of each real/imag component
- WORD_SZ, 32, packed complex width (2*WORD_MID)
- FRAC_BITS, 6, fractional bits per component
- DIV_ITERS, 38, restoring-division iterations (2*WORD_MID + FRAC_BITS)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present on cpx_A/cpx_B
- in_ready  out  1  block can accept operands
- cpx_A  in  WORD_SZ  dividend {real, imag}
- cpx_B  in  WORD_SZ  divisor {real, imag}
- out_valid  out  1  cpx_C/flags valid
- out_ready  in  1  consumer accepts result
- cpx_C  out  WORD_SZ  quotient {real, imag}
- div_zero  out  1  divisor was 0+0j
- sat  out  1  one or both components were clamped

Behaviour:
- Reset (rst high at clock edge): state=IDLE, in_ready=1, out_valid=0, cpx_C=0, div_zero=0, sat=0. Valid from any state, including mid-division; the in-flight operation is discarded.
- in_ready = (state==IDLE). Operands are accepted on an edge with in_valid && in_ready and registered internally. cpx_A/cpx_B may change after acceptance.
- States:
  - IDLE: on accept -> MULT.
  - MULT, 1 cycle: signed 16x16 products are registered.
    - num_r = Ar*Br + Ai*Bi
    - num_i = Ai*Br - Ar*Bi (33-bit signed)
    - den = Br² + Bi² (32-bit unsigned)
    - Sign and magnitude of each numerator are registered.
    - Dividend = |num| << FRAC_BITS (38 bits).
    - -> DIV.
  - DIV, DIV_ITERS cycles: one quotient bit per cycle per component, MSB first, restoring algorithm. An iteration counter runs 0..DIV_ITERS-1, then -> SAT.
  - SAT, 1 cycle: apply sign, clamp, and load cpx_C/div_zero/sat. -> DONE.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0. When out_valid && out_ready on an edge: out_valid=0, -> IDLE.
- Latency: out_valid is high in the cycle after the (DIV_ITERS+2)th rising edge following the accepting edge. With defaults, the accept at edge 0 gives out_valid after edge 40.
- No new accept until the result handshake completes. in_ready rises the cycle after the out handshake.
- Result outputs hold their last values in IDLE.
- Rounding: truncate toward zero (magnitude quotient, then negate if num<0). A -1 LSB result never appears from a sub-LSB magnitude.
- Saturation per component:
  - Positive result > 0x7FFF -> 0x7FFF.
  - Negative magnitude > 0x8000 -> 0x8000.
  - Exactly -32768 is not saturation.
  - sat = OR of both components' clamp conditions.
- Divide by zero (den==0): same fixed latency, cpx_C = 0x0000_0000, div_zero=1, sat=0.
- A = 0 with B ≠ 0: cpx_C = 0, flags 0.
- Simultaneous rst and in_valid: reset wins; nothing is accepted.
- Simultaneous rst and out_ready in DONE: reset wins.

Test Plan:
- Basic divide: A={0x0040,0x0080} (1+2j), B={0x00C0,0x0100} (3+4j) -> cpx_C={0x001C,0x0005}, div_zero=0, sat=0. out_valid appears exactly 40 edges after the accept.
- Self divide: A=B={0xFE70,0x00A0} -> cpx_C={0x0040,0x0000}.
- Divide by zero: A={0x0050,0x00A0}, B=0 -> cpx_C=0x00000000, div_zero=1, same latency.
- Saturation:
  - A={0x7FFF,0x0000}, B={0x0001,0x0000} -> {0x7FFF,0x0000}, sat=1.
  - A={0x8000,0x0000}, same B -> {0x8000,0x0000}, sat=1.
- Truncation toward zero: A={0xFFFF,0x0000}, B={0x0080,0x0000} -> cpx_C={0x0000,0x0000}, sat=0.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles in DONE -> cpx_C, flags and out_valid stable; in_ready=0; in_valid pulses ignored.
  - Then out_ready=1 -> out_valid=0 next cycle, in_ready=1.
  - Separately, assert rst during DIV -> next cycle in_ready=1, out_valid=0, cpx_C=0.
